// File: rtl/gray_to_bin_checker_if.sv
// Sample stream into the Gray decoder/checker and the decoded results coming back.
// The master drives samples and clear; the slave returns data, step flags and error count.
interface gray_to_bin_checker_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8
);
   logic             i_clr;
   logic             i_valid;
   logic [W-1:0]     i_gray;
   logic             o_valid;
   logic [W-1:0]     o_data;
   logic             o_up;
   logic             o_down;
   logic             o_step_err;
   logic [CNT_W-1:0] o_err_cnt;

   modport master (
      output i_clr, i_valid, i_gray,
      input  o_valid, o_data, o_up, o_down, o_step_err, o_err_cnt
   );

   modport slave (
      input  i_clr, i_valid, i_gray,
      output o_valid, o_data, o_up, o_down, o_step_err, o_err_cnt
   );
endinterface

// File: rtl/gray_to_bin_checker.sv
// Two-stage Gray-to-binary decoder that classifies each sample's step from the previous one
// and keeps a saturating count of illegal (non-adjacent) steps.
//
// state      | meaning
// HIST_EMPTY | no reference sample yet; next valid sample only loads prev
// HIST_TRACK | prev holds the last decoded sample; steps are classified
module gray_to_bin_checker #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   gray_to_bin_checker_if.slave  bus
);
   typedef enum logic {HIST_EMPTY, HIST_TRACK} hist_state_t;

   hist_state_t      hist_state;
   logic             s1_valid;
   logic [W-1:0]     s1_gray;
   logic [W-1:0]     s1_bin;
   logic [W-1:0]     prev;
   logic [W-1:0]     delta;
   logic             is_up;
   logic             is_down;
   logic             is_err;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_up;
   logic             out_down;
   logic             out_err;
   logic [CNT_W-1:0] err_cnt;

   // Each binary bit is the parity of the Gray bits at and above it.
   always_comb begin
      s1_bin = '0;
      for (int i = 0; i < W; i++) begin
         s1_bin[i] = ^(s1_gray >> i);
      end
   end

   // Up is tested first so that a width where +1 and -1 coincide resolves as up.
   always_comb begin
      delta   = s1_bin - prev;
      is_up   = (delta == W'(1));
      is_down = !is_up && (delta == '1);
      is_err  = (delta != '0) && !is_up && !is_down;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hist_state <= HIST_EMPTY;
         s1_valid   <= 1'b0;
         s1_gray    <= '0;
         prev       <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_up     <= 1'b0;
         out_down   <= 1'b0;
         out_err    <= 1'b0;
         err_cnt    <= '0;
      end else if (bus.i_clr) begin
         hist_state <= HIST_EMPTY;
         s1_valid   <= 1'b0;
         prev       <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_up     <= 1'b0;
         out_down   <= 1'b0;
         out_err    <= 1'b0;
         err_cnt    <= '0;
      end else begin
         s1_valid  <= bus.i_valid;
         if (bus.i_valid) begin
            s1_gray <= bus.i_gray;
         end
         out_valid <= s1_valid;
         out_up    <= 1'b0;
         out_down  <= 1'b0;
         out_err   <= 1'b0;
         if (s1_valid) begin
            out_data   <= s1_bin;
            prev       <= s1_bin;
            hist_state <= HIST_TRACK;
            if (hist_state == HIST_TRACK) begin
               out_up   <= is_up;
               out_down <= is_down;
               out_err  <= is_err;
               if (is_err && (err_cnt != '1)) begin
                  err_cnt <= err_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   assign bus.o_valid    = out_valid;
   assign bus.o_data     = out_data;
   assign bus.o_up       = out_up;
   assign bus.o_down     = out_down;
   assign bus.o_step_err = out_err;
   assign bus.o_err_cnt  = err_cnt;
endmodule

// File: tb/tb_gray_to_bin_checker.sv
// Bench for gray_to_bin_checker: table of samples with expected results fed through a
// scoreboard queue, plus clear/reset/saturation sequences.
module tb_gray_to_bin_checker;
   logic clk;
   logic rst;

   gray_to_bin_checker_if #(.W(4), .CNT_W(8)) bus_a ();
   gray_to_bin_checker_if #(.W(4), .CNT_W(2)) bus_b ();

   gray_to_bin_checker #(.W(4), .CNT_W(8)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
   gray_to_bin_checker #(.W(4), .CNT_W(2)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr_before;
      logic [3:0] gray;
      int         idle_after;
      logic [3:0] data;
      logic       up;
      logic       down;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   typedef struct {
      logic [3:0] data;
      logic       up;
      logic       down;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total  = 0;
   int   bad    = 0;
   int   pulses = 0;
   int   pushes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic void add(input logic c, input logic [3:0] g, input int idle,
                               input logic [3:0] d, input logic u, input logic dn,
                               input logic e, input logic [7:0] n);
      vec_t v;
      v.clr_before = c; v.gray = g; v.idle_after = idle;
      v.data = d; v.up = u; v.down = dn; v.err = e; v.cnt = n;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic v, input logic [3:0] g, input logic c);
      @(negedge clk);
      bus_a.i_valid = v;
      bus_a.i_gray  = g;
      bus_a.i_clr   = c;
   endtask

   task automatic push(input logic [3:0] d, input logic u, input logic dn,
                       input logic e, input logic [7:0] n);
      exp_t x;
      x.data = d; x.up = u; x.down = dn; x.err = e; x.cnt = n;
      sb.push_back(x);
      pushes++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.o_valid) begin
            pulses++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid actual data=%0h required=no output", bus_a.o_data);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("sample_result",
                   {bus_a.o_data, bus_a.o_up, bus_a.o_down, bus_a.o_step_err, bus_a.o_err_cnt},
                   {x.data, x.up, x.down, x.err, x.cnt});
            end
         end else begin
            chk("idle_flags", {bus_a.o_up, bus_a.o_down, bus_a.o_step_err}, 3'b000);
         end
      end
   end

   initial begin
      logic [3:0] g;
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      rst = 1'b1;
      bus_a.i_valid = 1'b0; bus_a.i_gray = 4'h0; bus_a.i_clr = 1'b0;
      bus_b.i_valid = 1'b0; bus_b.i_gray = 4'h0; bus_b.i_clr = 1'b0;

      // count up after reset
      add(0, 4'b0000, 0, 4'd0, 0, 0, 0, 8'd0);
      add(0, 4'b0001, 0, 4'd1, 1, 0, 0, 8'd0);
      add(0, 4'b0011, 0, 4'd2, 1, 0, 0, 8'd0);
      add(0, 4'b0010, 0, 4'd3, 1, 0, 0, 8'd0);
      add(0, 4'b0110, 0, 4'd4, 1, 0, 0, 8'd0);
      // full cycle with wrap both ways
      for (int i = 0; i < 16; i++) begin
         g = 4'(i ^ (i >> 1));
         add(i == 0, g, 0, 4'(i), i != 0, 0, 0, 8'd0);
      end
      add(0, 4'b0000, 0, 4'd0,  1, 0, 0, 8'd0);
      add(0, 4'b1000, 0, 4'd15, 0, 1, 0, 8'd0);
      // illegal step then repeat
      add(1, 4'b0000, 0, 4'd0, 0, 0, 0, 8'd0);
      add(0, 4'b0011, 0, 4'd2, 0, 0, 1, 8'd1);
      add(0, 4'b0011, 0, 4'd2, 0, 0, 0, 8'd1);
      // gaps and repeats
      add(1, 4'b0001, 5, 4'd1, 0, 0, 0, 8'd0);
      add(0, 4'b0001, 1, 4'd1, 0, 0, 0, 8'd0);
      add(0, 4'b0011, 0, 4'd2, 1, 0, 0, 8'd0);

      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {bus_a.o_valid, bus_a.o_data, bus_a.o_up, bus_a.o_down, bus_a.o_step_err, bus_a.o_err_cnt},
          17'd0);
      rst = 1'b0;

      foreach (vecs[k]) begin
         if (vecs[k].clr_before) begin
            idle(3);
            drive(1'b0, 4'h0, 1'b1);
            drive(1'b0, 4'h0, 1'b0);
            chk("clear_outputs", {bus_a.o_valid, bus_a.o_data, bus_a.o_err_cnt}, 13'd0);
         end
         drive(1'b1, vecs[k].gray, 1'b0);
         push(vecs[k].data, vecs[k].up, vecs[k].down, vecs[k].err, vecs[k].cnt);
         idle(vecs[k].idle_after);
      end
      idle(4);
      chk("table_pulses", pulses, pushes);

      // clear with a sample in stage 1 and one presented alongside the clear
      drive(1'b1, 4'b0000, 1'b0);
      push(4'd0, 0, 0, 1, 8'd1);
      idle(3);
      drive(1'b1, 4'b0001, 1'b0);
      drive(1'b1, 4'b0011, 1'b1);
      idle(3);
      chk("clr_cnt_data", {bus_a.o_data, bus_a.o_err_cnt}, 12'd0);
      drive(1'b1, 4'b0110, 1'b0);
      push(4'd4, 0, 0, 0, 8'd0);
      drive(1'b1, 4'b0111, 1'b0);
      push(4'd5, 1, 0, 0, 8'd0);
      drive(1'b1, 4'b1111, 1'b0);
      push(4'd10, 0, 0, 1, 8'd1);
      idle(3);
      chk("pre_reset_state", {bus_a.o_data, bus_a.o_err_cnt}, {4'd10, 8'd1});

      // asynchronous reset between edges, with a sample sitting in stage 1
      drive(1'b1, 4'b0011, 1'b0);
      @(posedge clk);
      bus_a.i_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk("async_reset", {bus_a.o_valid, bus_a.o_data, bus_a.o_err_cnt}, 13'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 4'b0110, 1'b0);
      push(4'd4, 0, 0, 0, 8'd0);
      idle(4);
      chk("scoreboard_empty", sb.size(), 0);
      chk("total_pulses", pulses, pushes);

      // saturation on the 2-bit counter instance
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j >= 2) begin
            chk("sat_cnt", {bus_b.o_valid, bus_b.o_step_err, bus_b.o_err_cnt},
                {1'b1, (j - 2) > 0, ((j - 2) > 3) ? 2'd3 : 2'(j - 2)});
         end
         bus_b.i_valid = (j < 8);
         bus_b.i_gray  = j[0] ? 4'b0011 : 4'b0000;
      end
      @(negedge clk);
      chk("sat_hold", {bus_b.o_valid, bus_b.o_err_cnt}, {1'b0, 2'd3});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gray_to_bin_checker.md
Name: gray_to_bin_checker

Overview:
- Receive-side counterpart to the team's binary-to-Gray encoder: accepts a stream of W-bit Gray-coded samples and returns the binary value.
- Also tracks sample-to-sample movement and flags illegal (non-adjacent) Gray transitions, with a saturating error counter.
- Sits downstream of any Gray-coded source, e.g. a counter crossing a clock domain or an encoder output, feeding control or monitoring logic.
- Two-stage registered pipeline with a valid qualifier.

Parameters:
- W, 4, data width of the Gray input and binary output (2..16).
- CNT_W, 8, width of the error counter.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high; all registers clear immediately on assertion.
- i_clr  input  1  synchronous clear of history, counter and pipeline valids.
- i_valid  input  1  i_gray carries a sample this cycle.
- i_gray  input  W  Gray-coded sample.
- o_valid  output  1  o_data and flags are valid this cycle (one-cycle pulse per sample).
- o_data  output  W  decoded binary value.
- o_up  output  1  sample is previous+1, modulo 2^W.
- o_down  output  1  sample is previous-1, modulo 2^W.
- o_step_err  output  1  sample differs from previous by more than ±1.
- o_err_cnt  output  CNT_W  count of step errors since reset/clear; saturating.

Behaviour:
- Reset state: all outputs 0, stage valids 0, history state HIST_EMPTY, prev register 0.
- Stage 1 (edge k, i_valid=1): register i_gray and valid.
- Decode: combinational on the stage-1 register.
  - b[W-1] = g[W-1].
  - b[i] = b[i+1] XOR g[i] for i = W-2..0.
- Stage 2 (edge k+1): register o_data, o_valid=1, flags, prev.
- Latency: fixed 2 edges. Throughput: one sample per cycle, back-to-back, no stalls, no backpressure.
- Outputs while o_valid=0:
  - o_data holds its last value.
  - o_up, o_down, o_step_err are 0.
- History FSM, two states:
  - HIST_EMPTY: the first valid sample after reset or clear produces o_valid with all flags 0. It loads prev and moves to HIST_TRACK.
  - HIST_TRACK: each valid sample computes d = (new - prev) mod 2^W.
    - d = 1 → o_up.
    - d = 2^W-1 → o_down.
    - d = 0 → no flag (repeat is legal).
    - any other d → o_step_err.
    - prev is updated to new in every case.
- Direction flags are mutually exclusive. For W=1 the up/down ambiguity is resolved as up.
- Wrap-around is legal and is not an error:
  - max → 0 is up.
  - 0 → max is down.
- o_err_cnt:
  - Increments in the same cycle o_step_err is asserted.
  - Saturates at 2^CNT_W-1 and never wraps.
- Cycles with i_valid=0 do not disturb prev. Gaps between samples are transparent.
- i_clr=1 at an edge:
  - Clears stage valids, o_valid, flags, o_err_cnt and prev.
  - FSM returns to HIST_EMPTY.
  - o_data is cleared to 0.
  - A sample presented with i_clr in the same cycle is dropped.
  - Samples already in stage 1 are discarded; i_clr has priority over everything except i_rst.
- i_rst asserted mid-stream:
  - Immediate clear identical to the reset state.
  - The first sample after deassertion is treated as HIST_EMPTY.
- No X propagation: i_gray is ignored when i_valid=0.

Test Plan:
- Reset then count up: release i_rst, drive W=4 Gray sequence 0000,0001,0011,0010,0110 back-to-back.
  - Expect o_data 0,1,2,3,4 appearing 2 edges after each input.
  - Expect o_up=1 on samples 2-5, no flag on the first sample, o_err_cnt=0.
- Full cycle and wrap: drive all 16 Gray codes of 0..15 ascending, then 0000.
  - Expect every decode correct and o_up on 1000→0000 (15→0).
  - Then drive 0000→1000: expect o_down, o_step_err=0.
- Illegal step: after 0000 (0) drive 0011 (2).
  - Expect o_step_err=1 and o_err_cnt=1.
  - Then 0011 again: no flag, count stays 1.
- Gaps and repeats: valid samples 0001, idle 5 cycles, 0001, idle, 0011.
  - Expect flags none (repeat), then o_up. o_valid pulses exactly 3 times.
- Saturation: CNT_W=2, alternate 0000/0011 eight times.
  - Expect o_err_cnt to reach 3 and hold at 3.
- Clear/reset mid-stream:
  - Assert i_clr together with a valid sample. Expect that sample produces no o_valid, o_err_cnt=0, and the next sample yields no flags.
  - Pulse i_rst asynchronously between clock edges. Expect outputs to zero immediately.
